control_mem: RTL and testbench
==============================

# control_mem

Memory-access stage between the EX stage (`controlALU`) and writeback. It consumes the EX/MEM register and its level-style ready signal, and performs an optional data-memory read or write over a req/ack interface. It loads a MEM/WB register, holds it until writeback flushes it, and then returns a one-cycle flush pulse to EX to release the EX/MEM register.

## Interface
- `MEM_TIMEOUT`, 255: max ACCESS cycles without `i_dmem_ack` before abort; legal range 1..65535.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `i_alu_ready`  in  1  EX/MEM occupied; level, rises when a new result is valid.
- `i_result`  in  32  ALU result; the memory address for loads and stores.
- `i_store_data`  in  32  store write data.
- `i_mem_read`  in  1  load request.
- `i_mem_write`  in  1  store request.
- `i_rd`  in  5  destination register.
- `o_flush`  out  1  one-cycle pulse to EX; releases EX/MEM.
- `o_dmem_req`  out  1  data memory request, held until ack or timeout.
- `o_dmem_we`  out  1  1 = write.
- `o_dmem_addr`  out  32  address.
- `o_dmem_wdata`  out  32  write data.
- `i_dmem_ack`  in  1  request completed; read data valid in the same cycle.
- `i_dmem_rdata`  in  32  read data.
- `o_wb_data`  out  32  MEM/WB data.
- `o_wb_rd`  out  5  MEM/WB destination.
- `o_wb_en`  out  1  register-file write enable.
- `o_mem_ready`  out  1  MEM/WB occupied.
- `i_flush`  in  1  writeback consumed MEM/WB.
- `o_timeout`  out  1  sticky error; a memory access was aborted.

## Operation
- The four states are IDLE, ACCESS, WAIT_WB and RELEASE.
- Rising-edge detect: `r_ready_d` samples `i_alu_ready` every cycle.
  - A rise (`i_alu_ready & !r_ready_d`) sets `r_pending` in any state.
  - `r_pending` clears when IDLE captures.
  - A level held high never causes a second capture.
- IDLE, when a rise is seen or `r_pending` is set:
  - Latch `i_result`, `i_store_data`, `i_mem_read`, `i_mem_write` and `i_rd`.
  - If read or write is set, go to ACCESS.
  - Otherwise load MEM/WB with `o_wb_data`=result and `o_wb_en`=(rd!=0), then go to WAIT_WB.
- ACCESS: `o_dmem_req`=1, `o_dmem_we`=latched write, and `o_dmem_addr` / `o_dmem_wdata` are driven from the latches. All four are stable until exit.
  - The 16-bit timeout counter clears on entry and increments once per ACCESS cycle.
  - On ack: load `o_wb_data` with rdata if the op is a load, else with the result. `o_wb_en`=(load & rd!=0). Go to WAIT_WB.
  - If the count reaches `MEM_TIMEOUT` without ack: `o_timeout`<=1, `o_wb_data`<=0, `o_wb_en`<=0, go to WAIT_WB.
  - If ack and timeout occur in the same cycle, ack wins.
- Read and write both set: treated as a store (`o_dmem_we`=1, `o_wb_en`=0).
- WAIT_WB: `o_mem_ready`=1. On `i_flush`, go to RELEASE.
- RELEASE: `o_flush`=1 for exactly one cycle, then go to IDLE.
- EX is released only after writeback has consumed the data, so no result is ever dropped.
- MEM/WB outputs hold their values until the next load; RELEASE does not clear them.
- Ignored inputs:
  - `i_dmem_ack` outside ACCESS.
  - `i_flush` outside WAIT_WB.
  - EX inputs outside the capture cycle.

## Timing
- All outputs are registered.
- Reset (`rst`=0 at an edge) returns IDLE and clears all outputs, `o_timeout`, `r_pending`, `r_ready_d` and the latches to 0. This applies in any state.
  - Mid-ACCESS, `o_dmem_req` falls after that edge.
  - A late ack is ignored.
- Capture edge E is the first edge at which IDLE sees a rise or `r_pending`.
- ALU-only op: `o_mem_ready`=1 and MEM/WB are valid after E (1-cycle latency).
- Memory op:
  - `o_dmem_req` is high after E.
  - Ack sampled at edge A loads MEM/WB, and `o_mem_ready`=1 after A.
  - `o_dmem_req` is low after A.
  - A zero-wait memory gives A = E+1.
- Timeout: `o_dmem_req` stays high for exactly `MEM_TIMEOUT` cycles.
- `i_flush` sampled at edge F:
  - `o_mem_ready`=0 and `o_flush`=1 after F.
  - `o_flush`=0 and state=IDLE after F+1.
  - The next capture is possible at edge F+2.

## Test plan
- ALU op: result=0x0000002A, rd=5, no mem.
  - One edge after the rise: `o_mem_ready`=1, `o_wb_data`=0x2A, `o_wb_rd`=5, `o_wb_en`=1, `o_dmem_req` never asserted.
  - On an `i_flush` pulse: a single-cycle `o_flush`, then IDLE.
- Store: addr 0x100, data 0xDEADBEEF, ack after 3 cycles.
  - req/we/addr/wdata stable for 3 cycles.
  - Then `o_wb_en`=0 and `o_mem_ready`=1.
- Load: addr 0x104, rd=7, ack with rdata 0x12345678.
  - `o_wb_data`=0x12345678, `o_wb_rd`=7, `o_wb_en`=1.
- Timeout: `MEM_TIMEOUT`=4, no ack.
  - req high exactly 4 cycles, then `o_timeout`=1 (stays 1 across later ops).
  - `o_wb_data`=0 and `o_wb_en`=0.
- Level hold and rd=0: `i_alu_ready` held high through RELEASE.
  - Exactly one capture occurs.
  - For rd=0, `o_wb_en`=0.
  - A stray ack or `i_flush` in IDLE causes no state change.
- Reset mid-ACCESS: assert `rst`=0 for one edge while req=1.
  - After that edge, all outputs are 0.
  - A subsequent ack is ignored and the block stays IDLE.

Source files
------------

// File: rtl/control_mem.sv
// rtl/control_mem.sv - Memory-access pipeline stage between EX and writeback.
// Captures EX/MEM on a ready rise, runs an optional req/ack access, holds MEM/WB until flushed.
module control_mem #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_alu_ready,
   input  logic [31:0] i_result,
   input  logic [31:0] i_store_data,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic [4:0]  i_rd,
   output logic        o_flush,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata,
   output logic [31:0] o_wb_data,
   output logic [4:0]  o_wb_rd,
   output logic        o_wb_en,
   output logic        o_mem_ready,
   input  logic        i_flush,
   output logic        o_timeout
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT_WB, RELEASE} state_t;

   state_t      state_q;
   logic        ready_dly_q;
   logic        pending_q;
   logic [31:0] result_q;
   logic [31:0] wdata_q;
   logic        rd_op_q;
   logic        wr_op_q;
   logic [4:0]  rd_q;
   logic [15:0] cnt_q;

   logic rise;
   logic load_op;
   logic cnt_hit;

   assign rise    = i_alu_ready & ~ready_dly_q;
   // A read with write also set behaves as a store.
   assign load_op = rd_op_q & ~wr_op_q;
   assign cnt_hit = ({1'b0, cnt_q} + 17'd1) == 17'(MEM_TIMEOUT);

   assign o_dmem_addr  = result_q;
   assign o_dmem_wdata = wdata_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         ready_dly_q <= 1'b0;
         pending_q   <= 1'b0;
         result_q    <= '0;
         wdata_q     <= '0;
         rd_op_q     <= 1'b0;
         wr_op_q     <= 1'b0;
         rd_q        <= '0;
         cnt_q       <= '0;
         o_flush     <= 1'b0;
         o_dmem_req  <= 1'b0;
         o_dmem_we   <= 1'b0;
         o_wb_data   <= '0;
         o_wb_rd     <= '0;
         o_wb_en     <= 1'b0;
         o_mem_ready <= 1'b0;
         o_timeout   <= 1'b0;
      end else begin
         ready_dly_q <= i_alu_ready;
         o_flush     <= 1'b0;
         if (rise) pending_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (rise || pending_q) begin
                  pending_q <= 1'b0;
                  result_q  <= i_result;
                  wdata_q   <= i_store_data;
                  rd_op_q   <= i_mem_read;
                  wr_op_q   <= i_mem_write;
                  rd_q      <= i_rd;
                  if (i_mem_read || i_mem_write) begin
                     o_dmem_req <= 1'b1;
                     o_dmem_we  <= i_mem_write;
                     cnt_q      <= '0;
                     state_q    <= ACCESS;
                  end else begin
                     o_wb_data   <= i_result;
                     o_wb_rd     <= i_rd;
                     o_wb_en     <= (i_rd != 5'd0);
                     o_mem_ready <= 1'b1;
                     state_q     <= WAIT_WB;
                  end
               end
            end
            ACCESS: begin
               cnt_q <= cnt_q + 16'd1;
               // Ack takes priority over a coincident timeout.
               if (i_dmem_ack) begin
                  o_wb_data   <= load_op ? i_dmem_rdata : result_q;
                  o_wb_rd     <= rd_q;
                  o_wb_en     <= load_op && (rd_q != 5'd0);
                  o_dmem_req  <= 1'b0;
                  o_dmem_we   <= 1'b0;
                  o_mem_ready <= 1'b1;
                  state_q     <= WAIT_WB;
               end else if (cnt_hit) begin
                  o_timeout   <= 1'b1;
                  o_wb_data   <= '0;
                  o_wb_rd     <= rd_q;
                  o_wb_en     <= 1'b0;
                  o_dmem_req  <= 1'b0;
                  o_dmem_we   <= 1'b0;
                  o_mem_ready <= 1'b1;
                  state_q     <= WAIT_WB;
               end
            end
            WAIT_WB: begin
               if (i_flush) begin
                  o_mem_ready <= 1'b0;
                  o_flush     <= 1'b1;
                  state_q     <= RELEASE;
               end
            end
            RELEASE: begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_control_mem.sv
// tb/tb_control_mem.sv - Scoreboard bench for control_mem.
module tb_control_mem;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        en;
      logic        tmo;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_alu_ready = 1'b0;
   logic [31:0] i_result = '0;
   logic [31:0] i_store_data = '0;
   logic        i_mem_read = 1'b0;
   logic        i_mem_write = 1'b0;
   logic [4:0]  i_rd = '0;
   logic        o_flush;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [31:0] o_dmem_addr;
   logic [31:0] o_dmem_wdata;
   logic        i_dmem_ack = 1'b0;
   logic [31:0] i_dmem_rdata = '0;
   logic [31:0] o_wb_data;
   logic [4:0]  o_wb_rd;
   logic        o_wb_en;
   logic        o_mem_ready;
   logic        i_flush = 1'b0;
   logic        o_timeout;

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];
   logic mr_prev = 1'b0;

   control_mem #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .i_alu_ready(i_alu_ready), .i_result(i_result),
      .i_store_data(i_store_data), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
      .i_rd(i_rd), .o_flush(o_flush), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
      .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack),
      .i_dmem_rdata(i_dmem_rdata), .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd),
      .o_wb_en(o_wb_en), .o_mem_ready(o_mem_ready), .i_flush(i_flush), .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic [4:0] r, input logic e, input logic t);
      exp_t x;
      x.data = d; x.rd = r; x.en = e; x.tmo = t;
      sb_q.push_back(x);
   endtask

   task automatic do_flush();
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      chk("flush_pulse", {31'd0, o_flush}, 32'd1);
      chk("ready_drop", {31'd0, o_mem_ready}, 32'd0);
      tick();
      chk("flush_end", {31'd0, o_flush}, 32'd0);
   endtask

   task automatic issue(input logic [31:0] res, input logic [31:0] sd,
                        input logic rd_op, input logic wr_op, input logic [4:0] rd);
      i_result = res; i_store_data = sd; i_mem_read = rd_op; i_mem_write = wr_op; i_rd = rd;
      i_alu_ready = 1'b1;
   endtask

   // Monitor: compare MEM/WB each time it becomes occupied.
   always @(negedge clk) begin
      if (o_mem_ready && !mr_prev) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_wb", {31'd0, o_mem_ready}, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("wb_data", o_wb_data, e.data);
            chk("wb_rd", {27'd0, o_wb_rd}, {27'd0, e.rd});
            chk("wb_en", {31'd0, o_wb_en}, {31'd0, e.en});
            chk("timeout", {31'd0, o_timeout}, {31'd0, e.tmo});
         end
      end
      mr_prev = o_mem_ready;
   end

   initial begin
      int n;
      tick();
      tick();
      chk("rst_outputs", {27'd0, o_flush, o_dmem_req, o_dmem_we, o_mem_ready, o_wb_en}, 32'd0);
      chk("rst_wb", o_wb_data | o_dmem_addr | {27'd0, o_wb_rd}, 32'd0);
      rst = 1'b1;
      tick();

      // ALU-only op
      issue(32'h2A, 32'h0, 1'b0, 1'b0, 5'd5);
      push(32'h2A, 5'd5, 1'b1, 1'b0);
      tick();
      i_alu_ready = 1'b0;
      chk("alu_ready1", {31'd0, o_mem_ready}, 32'd1);
      chk("alu_noreq", {31'd0, o_dmem_req}, 32'd0);
      tick();
      chk("alu_noreq2", {31'd0, o_dmem_req}, 32'd0);
      do_flush();

      // Store, ack after 3 request cycles
      issue(32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 5'd3);
      push(32'h100, 5'd3, 1'b0, 1'b0);
      tick();
      i_alu_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("st_req", {31'd0, o_dmem_req}, 32'd1);
         chk("st_we", {31'd0, o_dmem_we}, 32'd1);
         chk("st_addr", o_dmem_addr, 32'h100);
         chk("st_wdata", o_dmem_wdata, 32'hDEADBEEF);
         if (i < 2) tick();
      end
      i_dmem_ack = 1'b1;
      tick();
      i_dmem_ack = 1'b0;
      chk("st_req_low", {31'd0, o_dmem_req}, 32'd0);
      chk("st_ready", {31'd0, o_mem_ready}, 32'd1);
      do_flush();

      // Load, zero-wait
      issue(32'h104, 32'h0, 1'b1, 1'b0, 5'd7);
      push(32'h12345678, 5'd7, 1'b1, 1'b0);
      tick();
      i_alu_ready = 1'b0;
      chk("ld_req", {31'd0, o_dmem_req}, 32'd1);
      chk("ld_we", {31'd0, o_dmem_we}, 32'd0);
      i_dmem_ack = 1'b1;
      i_dmem_rdata = 32'h12345678;
      tick();
      i_dmem_ack = 1'b0;
      i_dmem_rdata = 32'h0;
      chk("ld_ready", {31'd0, o_mem_ready}, 32'd1);
      do_flush();

      // Timeout with no ack
      issue(32'h200, 32'h0, 1'b1, 1'b0, 5'd9);
      push(32'h0, 5'd9, 1'b0, 1'b1);
      tick();
      i_alu_ready = 1'b0;
      n = 0;
      while (o_dmem_req && n < 20) begin
         n++;
         tick();
      end
      chk("tmo_req_cycles", n, 32'd4);
      chk("tmo_sticky", {31'd0, o_timeout}, 32'd1);
      do_flush();

      // Level hold with rd=0
      issue(32'h55, 32'h0, 1'b0, 1'b0, 5'd0);
      push(32'h55, 5'd0, 1'b0, 1'b1);
      tick();
      chk("lvl_ready", {31'd0, o_mem_ready}, 32'd1);
      do_flush();
      n = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (o_mem_ready || o_dmem_req) n++;
      end
      chk("lvl_single_capture", n, 32'd0);
      i_dmem_ack = 1'b1;
      i_flush = 1'b1;
      tick();
      i_dmem_ack = 1'b0;
      i_flush = 1'b0;
      tick();
      chk("stray_idle", {29'd0, o_flush, o_mem_ready, o_dmem_req}, 32'd0);
      chk("tmo_still", {31'd0, o_timeout}, 32'd1);
      i_alu_ready = 1'b0;
      tick();

      // Reset mid-ACCESS
      issue(32'h300, 32'hCAFEF00D, 1'b0, 1'b1, 5'd4);
      tick();
      i_alu_ready = 1'b0;
      chk("rm_req", {31'd0, o_dmem_req}, 32'd1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rm_outputs", {26'd0, o_flush, o_dmem_req, o_dmem_we, o_mem_ready, o_wb_en, o_timeout}, 32'd0);
      chk("rm_data", o_wb_data | o_dmem_addr | o_dmem_wdata, 32'd0);
      i_dmem_ack = 1'b1;
      i_dmem_rdata = 32'hFFFFFFFF;
      tick();
      i_dmem_ack = 1'b0;
      tick();
      chk("rm_late_ack", {29'd0, o_dmem_req, o_mem_ready, o_flush}, 32'd0);
      chk("rm_wb_data", o_wb_data, 32'd0);

      tick();
      chk("sb_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
